// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter in front of a single-port RAM and a
// handshaked IO bus; one access in flight at a time, one response pulse per access.
module mem_arbiter #(
   parameter int unsigned IO_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [47:0] req0_addr,
   input  logic [63:0] req0_wdata,
   input  logic [7:0]  req0_mask,
   input  logic [2:0]  req0_shift,
   input  logic        req0_rw,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [47:0] req1_addr,
   input  logic [63:0] req1_wdata,
   input  logic [7:0]  req1_mask,
   input  logic [2:0]  req1_shift,
   input  logic        req1_rw,
   output logic        rsp0_valid,
   output logic [63:0] rsp0_rdata,
   output logic        rsp0_err,
   output logic        rsp1_valid,
   output logic [63:0] rsp1_rdata,
   output logic        rsp1_err,
   output logic [20:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_mask,
   output logic [2:0]  mem_shift,
   output logic        mem_rw,
   output logic        mem_enable,
   input  logic [63:0] mem_rdata,
   output logic [15:0] io_port,
   output logic [15:0] io_wdata,
   output logic        io_enable,
   output logic        io_rw,
   input  logic        io_ack,
   input  logic [15:0] io_rdata
);

   localparam logic [7:0] TMO_LAST = 8'(IO_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MEM     = 3'd1,
      RESP    = 3'd2,
      IO_WAIT = 3'd3,
      IO_RESP = 3'd4
   } state_t;

   state_t       state_q, state_d;
   logic         last_q, last_d;
   logic [7:0]   cnt_q, cnt_d;
   logic [63:0]  rdata_q, rdata_d;
   logic         err_q, err_d;
   logic         run_q;

   logic         id_q;
   logic         rw_q;
   logic [20:0]  word_q;
   logic [15:0]  port_q;
   logic [63:0]  wdata_q;
   logic [7:0]   mask_q;
   logic [2:0]   shift_q;

   logic [1:0]   req_valid;
   logic         grant_id;
   logic         accept;
   logic [47:0]  sel_addr;
   logic [63:0]  sel_wdata;
   logic [7:0]   sel_mask;
   logic [2:0]   sel_shift;
   logic         sel_rw;
   logic [1:0]   rsp_valid;
   logic [63:0]  rsp_rdata;
   logic         rsp_err;
   logic         unused_addr_bits;

   assign req_valid = {req1_valid, req0_valid};

   // Only the RAM word index and the IO port field of the address are consumed.
   assign unused_addr_bits = ^{req0_addr[46:24], req1_addr[46:24]};

   // A lone requester always wins; on contention the one not served last wins.
   always_comb begin
      grant_id = ~last_q;
      if (req_valid == 2'b01) begin
         grant_id = 1'b0;
      end else if (req_valid == 2'b10) begin
         grant_id = 1'b1;
      end
   end

   assign sel_addr  = grant_id ? req1_addr  : req0_addr;
   assign sel_wdata = grant_id ? req1_wdata : req0_wdata;
   assign sel_mask  = grant_id ? req1_mask  : req0_mask;
   assign sel_shift = grant_id ? req1_shift : req0_shift;
   assign sel_rw    = grant_id ? req1_rw    : req0_rw;

   // run_q holds off acceptance until the first edge after reset release.
   assign accept     = (state_q == IDLE) && run_q && req_valid[grant_id];
   assign req0_ready = accept && (grant_id == 1'b0);
   assign req1_ready = accept && (grant_id == 1'b1);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               last_d  = grant_id;
               cnt_d   = 8'd0;
               rdata_d = 64'd0;
               err_d   = 1'b0;
               state_d = sel_addr[47] ? IO_WAIT : MEM;
            end
         end
         MEM:  state_d = RESP;
         RESP: state_d = IDLE;
         IO_WAIT: begin
            if (io_ack) begin
               rdata_d = rw_q ? 64'd0 : {48'd0, io_rdata};
               err_d   = 1'b0;
               state_d = IO_RESP;
            end else if (cnt_q == TMO_LAST) begin
               rdata_d = 64'd0;
               err_d   = 1'b1;
               state_d = IO_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         IO_RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         run_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_q    <= 1'b0;
         rw_q    <= 1'b0;
         word_q  <= 21'd0;
         port_q  <= 16'd0;
         wdata_q <= 64'd0;
         mask_q  <= 8'd0;
         shift_q <= 3'd0;
      end else if (accept) begin
         id_q    <= grant_id;
         rw_q    <= sel_rw;
         word_q  <= sel_addr[23:3];
         port_q  <= sel_addr[15:0];
         wdata_q <= sel_wdata;
         mask_q  <= sel_mask;
         shift_q <= sel_shift;
      end
   end

   assign mem_enable = (state_q == MEM);
   assign mem_rw     = (state_q == MEM) && rw_q;
   assign mem_addr   = word_q;
   assign mem_wdata  = wdata_q;
   assign mem_mask   = mask_q;
   assign mem_shift  = shift_q;

   assign io_enable  = (state_q == IO_WAIT);
   assign io_rw      = (state_q == IO_WAIT) && rw_q;
   assign io_port    = port_q;
   assign io_wdata   = wdata_q[15:0];

   // RAM read data arrives in the RESP cycle itself and is passed straight through.
   always_comb begin
      rsp_rdata = 64'd0;
      rsp_err   = 1'b0;
      if (state_q == RESP) begin
         rsp_rdata = rw_q ? 64'd0 : mem_rdata;
      end else if (state_q == IO_RESP) begin
         rsp_rdata = rdata_q;
         rsp_err   = err_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rsp
         assign rsp_valid[gi] = ((state_q == RESP) || (state_q == IO_RESP)) && (id_q == gi[0]);
      end
   endgenerate

   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_rdata = rsp_valid[0] ? rsp_rdata : 64'd0;
   assign rsp1_rdata = rsp_valid[1] ? rsp_rdata : 64'd0;
   assign rsp0_err   = rsp_valid[0] && rsp_err;
   assign rsp1_err   = rsp_valid[1] && rsp_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM path, round-robin, IO ack/timeout, mid-access reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req0_rw;
   logic [47:0] req0_addr;
   logic [63:0] req0_wdata;
   logic [7:0]  req0_mask;
   logic [2:0]  req0_shift;
   logic        req1_valid, req1_ready, req1_rw;
   logic [47:0] req1_addr;
   logic [63:0] req1_wdata;
   logic [7:0]  req1_mask;
   logic [2:0]  req1_shift;
   logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [63:0] rsp0_rdata, rsp1_rdata;
   logic [20:0] mem_addr;
   logic [63:0] mem_wdata, mem_rdata;
   logic [7:0]  mem_mask;
   logic [2:0]  mem_shift;
   logic        mem_rw, mem_enable;
   logic [15:0] io_port, io_wdata, io_rdata;
   logic        io_enable, io_rw, io_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.IO_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_mask(req0_mask), .req0_shift(req0_shift), .req0_rw(req0_rw),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_mask(req1_mask), .req1_shift(req1_shift), .req1_rw(req1_rw),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_shift(mem_shift),
      .mem_rw(mem_rw), .mem_enable(mem_enable), .mem_rdata(mem_rdata),
      .io_port(io_port), .io_wdata(io_wdata), .io_enable(io_enable), .io_rw(io_rw),
      .io_ack(io_ack), .io_rdata(io_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int id, input logic v, input logic [47:0] a,
                            input logic [63:0] wd, input logic rw);
      if (id == 0) begin
         req0_valid = v; req0_addr = a; req0_wdata = wd; req0_rw = rw;
      end else begin
         req1_valid = v; req1_addr = a; req1_wdata = wd; req1_rw = rw;
      end
   endtask

   // IO access acknowledged on the 4th IO_WAIT cycle (also the timeout cycle for IO_TIMEOUT=4).
   task automatic io_txn(input int id, input logic [47:0] a, input logic rw,
                         input logic [15:0] wd, input logic [15:0] rd_in,
                         input logic [63:0] exp_rdata);
      drive_req(id, 1'b1, a, {48'd0, wd}, rw);
      #1;
      check("io_ready", id == 0 ? req0_ready : req1_ready, 1);
      step();
      drive_req(id, 1'b0, a, {48'd0, wd}, rw);
      check("io_enable", io_enable, 1);
      check("io_port", io_port, a[15:0]);
      check("io_wdata", io_wdata, wd);
      check("io_rw", io_rw, rw);
      for (int c = 2; c <= 4; c++) step();
      check("io_en_c4", io_enable, 1);
      io_ack = 1'b1;
      io_rdata = rd_in;
      step();
      io_ack = 1'b0;
      io_rdata = 16'h0;
      check("io_resp_en", io_enable, 0);
      check("io_rsp_valid", id == 0 ? rsp0_valid : rsp1_valid, 1);
      check("io_rsp_other", id == 0 ? rsp1_valid : rsp0_valid, 0);
      check("io_rsp_rdata", id == 0 ? rsp0_rdata : rsp1_rdata, exp_rdata);
      check("io_rsp_err", id == 0 ? rsp0_err : rsp1_err, 0);
      step();
      check("io_rsp_done", id == 0 ? rsp0_valid : rsp1_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b0;
      req0_valid = 0; req0_addr = '0; req0_wdata = '0; req0_mask = 8'hFF; req0_shift = 3'd0; req0_rw = 0;
      req1_valid = 0; req1_addr = '0; req1_wdata = '0; req1_mask = 8'h0F; req1_shift = 3'd2; req1_rw = 0;
      mem_rdata = '0; io_ack = 0; io_rdata = '0;
      step();
      step();
      check("rst_mem_enable", mem_enable, 0);
      check("rst_io_enable", io_enable, 0);
      check("rst_rsp0", rsp0_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      reset = 1'b1;
      step();

      // RAM read from requester 0
      drive_req(0, 1'b1, 48'h0000_0000_0040, 64'h0, 1'b0);
      #1;
      check("s1_ready0", req0_ready, 1);
      check("s1_ready1", req1_ready, 0);
      step();
      req0_valid = 0;
      check("s1_mem_enable", mem_enable, 1);
      check("s1_mem_addr", mem_addr, 21'h8);
      check("s1_mem_rw", mem_rw, 0);
      check("s1_ready_mem", req0_ready, 0);
      mem_rdata = 64'h1122334455667788;
      step();
      check("s1_rsp0_valid", rsp0_valid, 1);
      check("s1_rsp0_rdata", rsp0_rdata, 64'h1122334455667788);
      check("s1_rsp0_err", rsp0_err, 0);
      check("s1_rsp1_valid", rsp1_valid, 0);
      check("s1_mem_en_off", mem_enable, 0);
      step();
      check("s1_rsp0_idle", rsp0_valid, 0);
      check("s1_rdata_idle", rsp0_rdata, 0);

      // IO write from requester 1, ack on 4th wait cycle
      io_txn(1, 48'h8000_0000_0012, 1'b1, 16'hBEEF, 16'h1234, 64'd0);

      // Both requesters held valid: grants alternate 0,1,0,1, one accept per 3 cycles
      mem_rdata = 64'hDEAD_BEEF_0000_0001;
      drive_req(0, 1'b1, 48'h0000_0000_0100, 64'h0, 1'b0);
      drive_req(1, 1'b1, 48'h0000_0000_0208, 64'hCAFE, 1'b1);
      #1;
      for (int k = 0; k < 4; k++) begin
         logic g;
         g = k[0];
         check($sformatf("rr%0d_ready0", k), req0_ready, !g);
         check($sformatf("rr%0d_ready1", k), req1_ready, g);
         step();
         check($sformatf("rr%0d_mem_en", k), mem_enable, 1);
         check($sformatf("rr%0d_mem_addr", k), mem_addr, g ? 21'h41 : 21'h20);
         check($sformatf("rr%0d_mem_rw", k), mem_rw, g);
         check($sformatf("rr%0d_ready_busy", k), req0_ready | req1_ready, 0);
         step();
         check($sformatf("rr%0d_rsp0", k), rsp0_valid, !g);
         check($sformatf("rr%0d_rsp1", k), rsp1_valid, g);
         check($sformatf("rr%0d_rdata", k), g ? rsp1_rdata : rsp0_rdata,
               g ? 64'd0 : 64'hDEAD_BEEF_0000_0001);
         step();
      end
      req0_valid = 0;
      req1_valid = 0;
      step();

      // IO read from requester 0 with no ack: times out after 4 cycles
      drive_req(0, 1'b1, 48'h8000_0000_0034, 64'h0, 1'b0);
      #1;
      step();
      req0_valid = 0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (!io_enable) break;
         n++;
         step();
      end
      check("to_io_cycles", n, 4);
      check("to_rsp0_valid", rsp0_valid, 1);
      check("to_rsp0_err", rsp0_err, 1);
      check("to_rsp0_rdata", rsp0_rdata, 0);
      step();
      check("to_rsp0_done", rsp0_valid, 0);
      check("to_err_idle", rsp0_err, 0);

      // IO read acknowledged on the timeout cycle: ack wins
      io_txn(0, 48'h8000_0000_0056, 1'b0, 16'h0, 16'hA5A5, 64'h0000_0000_0000_A5A5);

      // Reset during MEM aborts silently; after release req0 wins contention
      drive_req(0, 1'b1, 48'h0000_0000_0080, 64'h0, 1'b0);
      #1;
      step();
      req0_valid = 0;
      check("rs_mem_enable", mem_enable, 1);
      reset = 1'b0;
      #1;
      check("rs_mem_en_now", mem_enable, 0);
      check("rs_mem_addr_now", mem_addr, 0);
      check("rs_rsp0_now", rsp0_valid, 0);
      drive_req(0, 1'b1, 48'h0000_0000_0080, 64'h0, 1'b0);
      drive_req(1, 1'b1, 48'h0000_0000_0088, 64'h0, 1'b0);
      step();
      check("rs_rsp0_hold", rsp0_valid, 0);
      check("rs_ready_hold", req0_ready | req1_ready, 0);
      step();
      reset = 1'b1;
      step();
      check("rs_ready0", req0_ready, 1);
      check("rs_ready1", req1_ready, 0);
      step();
      req0_valid = 0;
      req1_valid = 0;
      check("rs_mem_addr", mem_addr, 21'h10);
      step();
      check("rs_rsp0", rsp0_valid, 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
